tdm_demux1x8: RTL and testbench

- Sequenced 1-to-8 demultiplexer: the receive-side counterpart of the team's 8:1 selector.
- Accepts a stream of WIDTH-bit beats, steers each into one of 8 registered output lanes, and presents the assembled 8-lane frame with a valid/ready handshake.
- Sits after a serialised link that was built by time-multiplexing 8 sources onto one wire.

---
 rtl/tdm_demux_pkg.sv | 8 +
 rtl/tdm_demux1x8_if.sv | 26 ++
 rtl/tdm_demux1x8_dec3to8.sv | 13 +
 rtl/tdm_demux1x8.sv | 96 +++++++++
 tb/tb_tdm_demux1x8.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux_pkg.sv
// tdm_demux1x8 shared types: lane count, lane index type, FSM states.
// The optional dup_err output is enabled by TDM_DEMUX_DUP_ERR_EN.
package tdm_demux_pkg;
   localparam int LANES = 8;
   localparam int SEL_W = 3;
   typedef enum logic {FILL, HOLD} state_t;
   typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

// File: rtl/tdm_demux1x8_if.sv
// Beat-in / frame-out bundle of the tdm_demux1x8 receive demux.
interface tdm_demux1x8_if #(
   parameter int WIDTH = 1
);
   import tdm_demux_pkg::*;

   logic [WIDTH-1:0]       in_data;
   logic                   in_valid;
   logic                   in_ready;
   lane_sel_t              in_sel;
   logic                   sel_mode;
   logic [LANES*WIDTH-1:0] out_lanes;
   logic [LANES-1:0]       lane_valid;
   logic                   frame_valid;
   logic                   frame_ready;

   modport master (
      output in_data, in_valid, in_sel, sel_mode, frame_ready,
      input  in_ready, out_lanes, lane_valid, frame_valid
   );

   modport slave (
      input  in_data, in_valid, in_sel, sel_mode, frame_ready,
      output in_ready, out_lanes, lane_valid, frame_valid
   );
endinterface

// File: rtl/tdm_demux1x8_dec3to8.sv
// One-hot lane write-enable decoder, gated by beat acceptance.
module dec3to8
   import tdm_demux_pkg::*;
(
   input  lane_sel_t        sel,
   input  logic             en,
   output logic [LANES-1:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end
endmodule

// File: rtl/tdm_demux1x8.sv
// Sequenced 1-to-8 demux: beats fill 8 lanes, frame handed off by valid/ready.
// Define TDM_DEMUX_DUP_ERR_EN to add the sticky dup_err output.
module tdm_demux1x8
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic           clk,
   input  logic           rst,
   tdm_demux1x8_if.slave  bus
`ifdef TDM_DEMUX_DUP_ERR_EN
   ,
   output logic           dup_err
`endif
);
   state_t           state, state_nx;
   lane_sel_t        idx;
   lane_sel_t        lane;
   logic             mode_q;
   logic             mode_eff;
   logic             accept;
   logic             take;
   logic [LANES-1:0] we;
   logic [LANES-1:0] valid_q;
   logic [LANES-1:0] valid_nx;
   logic [WIDTH-1:0] lanes [LANES];

   assign bus.in_ready    = (state == FILL) && !rst;
   assign bus.frame_valid = (state == HOLD);
   assign bus.lane_valid  = valid_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign take   = bus.frame_valid && bus.frame_ready;

   // Mode is only taken live on the first beat of a frame.
   assign mode_eff = (valid_q == '0) ? bus.sel_mode : mode_q;
   assign lane     = mode_eff ? bus.in_sel : idx;

   dec3to8 u_dec (
      .sel    (lane),
      .en     (accept),
      .onehot (we)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      valid_nx = valid_q;
      unique case (state)
         FILL: begin
            valid_nx = valid_q | we;
            if (valid_nx == '1) state_nx = HOLD;
         end
         HOLD: begin
            if (bus.frame_ready) begin
               state_nx = FILL;
               valid_nx = '0;
            end
         end
         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         mode_q  <= 1'b0;
         valid_q <= '0;
         for (int k = 0; k < LANES; k++) lanes[k] <= '0;
      end else begin
         valid_q <= valid_nx;
         if (take)                     idx <= '0;
         else if (accept && !mode_eff) idx <= idx + 3'd1;
         if (accept && valid_q == '0) mode_q <= bus.sel_mode;
         for (int k = 0; k < LANES; k++)
            if (we[k]) lanes[k] <= bus.in_data;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_out
      assign bus.out_lanes[k*WIDTH +: WIDTH] = lanes[k];
   end

`ifdef TDM_DEMUX_DUP_ERR_EN
   always_ff @(posedge clk) begin
      if (rst)
         dup_err <= 1'b0;
      else if (accept && mode_eff && valid_q[lane])
         dup_err <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_tdm_demux1x8.sv
// Scoreboard bench for tdm_demux1x8: directed cases then random traffic.
module tb_tdm_demux1x8;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tdm_demux1x8_if #(.WIDTH(W)) bus ();
`ifdef TDM_DEMUX_DUP_ERR_EN
   logic dup_err;
`endif

   tdm_demux1x8 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef TDM_DEMUX_DUP_ERR_EN
      ,
      .dup_err (dup_err)
`endif
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0]   m_lanes [8] = '{default: '0};
   logic [7:0]     m_mask = '0;
   logic           m_hold = 1'b0;
   logic           m_mode = 1'b0;
   logic           m_dup  = 1'b0;
   int             m_idx  = 0;
   logic [8*W-1:0] q [$];

   function automatic logic [8*W-1:0] pack();
      logic [8*W-1:0] r;
      for (int k = 0; k < 8; k++) r[k*W +: W] = m_lanes[k];
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
      end
   endtask

   // Reference: frame as an array of lanes plus a filled-lane set.
   always @(posedge clk) begin
      int l;
      if (rst) begin
         for (int k = 0; k < 8; k++) m_lanes[k] = '0;
         m_mask = '0; m_hold = 0; m_mode = 0; m_dup = 0; m_idx = 0;
         q.delete();
      end else if (m_hold) begin
         if (bus.frame_ready) begin
            m_hold = 0; m_mask = '0; m_idx = 0;
         end
      end else if (bus.in_valid) begin
         if (m_mask == 0) m_mode = bus.sel_mode;
         l = m_mode ? int'(bus.in_sel) : m_idx;
         if (m_mode && m_mask[l]) m_dup = 1;
         m_lanes[l] = bus.in_data;
         m_mask[l]  = 1'b1;
         if (!m_mode) m_idx = (m_idx + 1) % 8;
         if (m_mask == 8'hFF) begin
            m_hold = 1;
            q.push_back(pack());
         end
      end
   end

   always @(negedge clk) begin
      logic [8*W-1:0] e;
      chk("in_ready", 32'(bus.in_ready), 32'(!rst && !m_hold));
      chk("frame_valid", 32'(bus.frame_valid), 32'(m_hold));
      chk("lane_valid", 32'(bus.lane_valid), 32'(m_mask));
      chk("out_lanes", 32'(bus.out_lanes), 32'(pack()));
`ifdef TDM_DEMUX_DUP_ERR_EN
      chk("dup_err", 32'(dup_err), 32'(m_dup));
`endif
      if (!rst && bus.frame_valid && bus.frame_ready) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL frame: got %0h want none queued", bus.out_lanes);
         end else begin
            e = q.pop_front();
            chk("frame", 32'(bus.out_lanes), 32'(e));
         end
      end
   end

   task automatic drv(input logic v, input logic [W-1:0] d,
                      input logic [2:0] s, input logic m,
                      input logic fr);
      @(posedge clk); #1;
      bus.in_valid = v; bus.in_data = d; bus.in_sel = s;
      bus.sel_mode = m; bus.frame_ready = fr;
   endtask

   task automatic rs(input logic val);
      @(posedge clk); #1;
      rst = val;
   endtask

   task automatic drain();
      drv(0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [7:0]     b;
      logic [8*W-1:0] exp1;
      logic [8*W-1:0] expx;
      logic [2:0]     sq [8] = '{7, 3, 0, 5, 1, 6, 2, 4};
      logic [2:0]     rest [7] = '{0, 1, 3, 4, 5, 6, 7};
      bus.in_valid = 0; bus.in_data = 0; bus.in_sel = 0;
      bus.sel_mode = 0; bus.frame_ready = 0;
      rs(1); rs(0);

      b = 8'b01001101;
      exp1 = '0;
      for (int i = 0; i < 8; i++) begin
         drv(1, W'(b[i]), 0, 0, 0);
         exp1[i*W +: W] = W'(b[i]);
      end
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("auto_lv", 32'(bus.lane_valid), 32'hFF);
      chk("auto_fv", 32'(bus.frame_valid), 1);
      chk("auto_rdy", 32'(bus.in_ready), 0);
      chk("auto_lanes", 32'(bus.out_lanes), 32'(exp1));

      repeat (5) drv(1, 5, 0, 0, 0);
      @(negedge clk);
      chk("hold_lanes", 32'(bus.out_lanes), 32'(exp1));
      drv(1, 5, 0, 0, 1);
      drv(1, 6, 0, 0, 0);
      @(negedge clk);
      chk("rel_fv", 32'(bus.frame_valid), 0);
      chk("rel_rdy", 32'(bus.in_ready), 1);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rel_lv", 32'(bus.lane_valid), 32'h01);
      chk("rel_lane0", 32'(bus.out_lanes[2:0]), 6);
      for (int k = 1; k < 8; k++) drv(1, W'(k), 0, 0, 0);
      drain();

      for (int i = 0; i < 8; i++) drv(1, sq[i], sq[i], 1, 0);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      for (int k = 0; k < 8; k++) expx[k*W +: W] = W'(k);
      chk("expl_fv", 32'(bus.frame_valid), 1);
      chk("expl_lanes", 32'(bus.out_lanes), 32'(expx));
      drain();

      drv(1, 5, 2, 1, 0);
      drv(1, 6, 2, 1, 0);
      drv(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("dup_fv_early", 32'(bus.frame_valid), 0);
      for (int i = 1; i < 7; i++) drv(1, W'(rest[i]), rest[i], 0, 0);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("dup_fv", 32'(bus.frame_valid), 1);
      chk("dup_lane2", 32'(bus.out_lanes[8:6]), 6);
`ifdef TDM_DEMUX_DUP_ERR_EN
      chk("dup_flag", 32'(dup_err), 1);
`endif
      drain();

      drv(1, 1, 0, 0, 0);
      drv(1, 2, 0, 1, 0);
      drv(1, 3, 0, 1, 0);
      drv(1, 4, 7, 1, 0);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mode_lv", 32'(bus.lane_valid), 32'h0F);
      chk("mode_lane3", 32'(bus.out_lanes[11:9]), 4);

      rs(1);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_lanes", 32'(bus.out_lanes), 0);
      chk("rst_lv", 32'(bus.lane_valid), 0);
      chk("rst_rdy", 32'(bus.in_ready), 0);
      rs(0);
      drv(1, 7, 5, 0, 0);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_lv", 32'(bus.lane_valid), 32'h01);
      chk("post_rst_lane0", 32'(bus.out_lanes[2:0]), 7);

      for (int i = 0; i < 600; i++)
         drv(1'($urandom_range(0, 3) != 0), W'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      repeat (20) drv(0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("drain", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
